fb_port_arbiter: RTL
====================

# fb_port_arbiter

Single-port frame-buffer controller between the camera capture path and the VGA scan-out path in the 25 MHz domain. It generates write addresses for incoming camera pixels and buffers them in a small FIFO. It shares one BRAM port between VGA reads (absolute priority) and buffered camera writes, and drops whole frames when the write path cannot keep up.

## Interface
- NPIX, 307200: pixels per frame; addresses 0..NPIX-1
- ADDR_W, 19: BRAM address width
- DATA_W, 12: pixel width, RGB444
- FIFO_DEPTH, 8: write FIFO entries; power of two, ≥2
- i_clk25m  in  1  sole clock; all logic on its rising edge
- i_rst_clk25m  in  1  reset, synchronous, active-high
- i_cam_sof  in  1  one-cycle pulse marking camera frame start
- i_cam_valid  in  1  i_cam_data carries a pixel this cycle
- i_cam_data  in  DATA_W  camera pixel
- i_rd_en  in  1  VGA read request this cycle
- i_rd_addr  in  ADDR_W  VGA read address
- o_rd_data  out  DATA_W  read data, registered
- o_rd_valid  out  1  o_rd_data valid, registered
- o_bram_en  out  1  BRAM port enable
- o_bram_we  out  1  BRAM write enable
- o_bram_addr  out  ADDR_W  BRAM address
- o_bram_wdata  out  DATA_W  BRAM write data
- i_bram_rdata  in  DATA_W  BRAM read data; 1-cycle read latency
- o_frame_done  out  1  one-cycle pulse when pixel NPIX-1 of a frame is accepted
- o_overflow  out  1  sticky; set on first dropped pixel; cleared only by reset
- o_drop_cnt  out  8  count of aborted frames; saturates at 255

## Operation
- Capture FSM states: WAIT_SOF, CAPTURE, DROP. Reset state: WAIT_SOF.
  - WAIT_SOF: pixels are ignored. On i_cam_sof, go to CAPTURE and clear the pixel counter.
  - CAPTURE: when i_cam_valid and the FIFO is not full, push {pix_cnt, i_cam_data} and increment pix_cnt.
    - On the push with pix_cnt == NPIX-1: pulse o_frame_done and go to WAIT_SOF.
    - When i_cam_valid and the FIFO is full: drop the pixel, set o_overflow, increment o_drop_cnt, and go to DROP.
    - On i_cam_sof: increment o_drop_cnt (incomplete frame), clear pix_cnt, and stay in CAPTURE. If i_cam_valid is asserted in the same cycle, that pixel is pushed as address 0.
  - DROP: pixels are ignored. On i_cam_sof, go to CAPTURE and clear pix_cnt. A frame that went to DROP increments o_drop_cnt exactly once.
- Fullness for a push is evaluated on the FIFO count at the start of the cycle. A same-cycle pop does not make room for the push.
- Entries already in the FIFO are always written out. No state transition or SOF flushes the FIFO.
- Port arbitration, combinational, evaluated each cycle:
  - i_rd_en=1: read. o_bram_en=1, o_bram_we=0, o_bram_addr=i_rd_addr. No FIFO pop.
  - i_rd_en=0 and FIFO not empty: write. o_bram_en=1, o_bram_we=1, address and data taken from the FIFO head. The FIFO pops.
  - Otherwise: o_bram_en=0, o_bram_we=0. o_bram_addr and o_bram_wdata hold the FIFO head value, which is don't-care.
- The FIFO supports a simultaneous push and pop when it is non-full.

## Timing
- Read latency is 2 cycles. A request sampled in cycle t drives the BRAM address in cycle t. BRAM data returns in cycle t+1. o_rd_data and o_rd_valid are registered and are valid in cycle t+2.
- Back-to-back reads give one result per cycle in request order. When no read is issued, o_rd_valid=0 and o_rd_data holds its last value.
- Camera-pixel-to-BRAM-write latency is at least 1 cycle (the FIFO is registered). A pixel pushed in cycle t is written no earlier than cycle t+1 with the FIFO previously empty and i_rd_en=0.
- Writes stall indefinitely while i_rd_en=1. The VGA blanking intervals drain the FIFO.
- o_frame_done is asserted in the cycle after the accepting edge, for exactly 1 cycle.
- Reset values: FSM=WAIT_SOF, FIFO empty, pix_cnt=0, o_rd_valid=0, o_rd_data=0, o_frame_done=0, o_overflow=0, o_drop_cnt=0. After reset the BRAM outputs are 0 until the first request. Reset asserted mid-frame or mid-burst discards FIFO contents and any in-flight read valid.

## Test plan
- Reset, then SOF and 307200 valid pixels with i_rd_en=0 -> BRAM writes to addresses 0..307199 with matching data in order, one o_frame_done pulse, o_overflow=0, o_drop_cnt=0.
- Preload BRAM[5]=0xABC, then i_rd_en=1, i_rd_addr=5 for one cycle -> o_rd_valid=1 with o_rd_data=0xABC exactly 2 cycles later. Back-to-back reads of addresses 5,6,7 -> three consecutive valid cycles with data in order.
- Hold i_rd_en=1 while streaming 9 valid pixels, FIFO_DEPTH=8 -> first 8 pushed, 9th dropped, o_overflow=1, o_drop_cnt=1, FSM in DROP, further pixels ignored. Release i_rd_en -> 8 writes to addresses 0..7. Next SOF restarts at address 0.
- SOF, 100 pixels, then SOF plus a valid pixel in the same cycle -> o_drop_cnt=1, that pixel written to address 0, no o_frame_done.
- i_rd_en=1 and a non-empty FIFO in the same cycle -> o_bram_we=0 with the read address on the port; the FIFO count does not decrease.
- Reset asserted with 5 FIFO entries and a read in flight -> no further BRAM writes, o_rd_valid=0 on the next cycle, all status outputs 0.

Source files
------------

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - frame-buffer port arbiter: camera write FIFO sharing one BRAM port with VGA reads
module fb_port_arbiter #(
  parameter int NPIX       = 307200,
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              i_clk25m,
  input  logic              i_rst_clk25m,
  input  logic              i_cam_sof,
  input  logic              i_cam_valid,
  input  logic [DATA_W-1:0] i_cam_data,
  input  logic              i_rd_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_bram_en,
  output logic              o_bram_we,
  output logic [ADDR_W-1:0] o_bram_addr,
  output logic [DATA_W-1:0] o_bram_wdata,
  input  logic [DATA_W-1:0] i_bram_rdata,
  output logic              o_frame_done,
  output logic              o_overflow,
  output logic [7:0]        o_drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    CAPTURE  = 2'd1,
    DROP     = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pix_cnt;
  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_rd_pend;

  logic              w_full;
  logic              w_empty;
  logic              w_cap;
  logic              w_push;
  logic              w_drop;
  logic              w_pop;
  logic              w_done;
  logic [ADDR_W-1:0] w_push_addr;
  logic [1:0]        w_drop_inc;
  logic [8:0]        w_drop_sum;
  logic [ENT_W-1:0]  w_head;

  // Fullness uses the count at the start of the cycle; a same-cycle pop never frees room.
  assign w_full      = (r_count == (PTR_W+1)'(FIFO_DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_cap       = (r_state == CAPTURE) && i_cam_valid;
  assign w_push      = w_cap && !w_full;
  assign w_drop      = w_cap && w_full;
  assign w_push_addr = i_cam_sof ? '0 : r_pix_cnt;
  assign w_done      = w_push && (w_push_addr == ADDR_W'(NPIX - 1));
  assign w_pop       = !i_rd_en && !w_empty;

  // An SOF mid-frame aborts the old frame; a full FIFO in the same cycle also aborts the new one.
  assign w_drop_inc  = {1'b0, (r_state == CAPTURE) && i_cam_sof} + {1'b0, w_drop};
  assign w_drop_sum  = {1'b0, o_drop_cnt} + {7'b0, w_drop_inc};

  assign w_head       = r_mem[r_rd_ptr];
  assign o_bram_en    = i_rd_en || !w_empty;
  assign o_bram_we    = w_pop;
  assign o_bram_addr  = i_rd_en ? i_rd_addr : w_head[ENT_W-1:DATA_W];
  assign o_bram_wdata = w_head[DATA_W-1:0];

  always_ff @(posedge i_clk25m) begin
    if (i_rst_clk25m) begin
      r_state      <= WAIT_SOF;
      r_pix_cnt    <= '0;
      o_frame_done <= 1'b0;
      o_overflow   <= 1'b0;
      o_drop_cnt   <= '0;
    end else begin
      o_frame_done <= w_done;
      if (w_drop) begin
        o_overflow <= 1'b1;
      end
      o_drop_cnt <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];
      case (r_state)
        WAIT_SOF, DROP: begin
          if (i_cam_sof) begin
            r_state   <= CAPTURE;
            r_pix_cnt <= '0;
          end
        end
        CAPTURE: begin
          if (w_drop) begin
            r_state <= DROP;
          end else if (w_done) begin
            r_state   <= WAIT_SOF;
            r_pix_cnt <= '0;
          end else if (w_push) begin
            r_pix_cnt <= w_push_addr + ADDR_W'(1);
          end else if (i_cam_sof) begin
            r_pix_cnt <= '0;
          end
        end
        default: begin
          r_state   <= WAIT_SOF;
          r_pix_cnt <= '0;
        end
      endcase
    end
  end

  // Storage is cleared on reset so the idle BRAM address/data outputs read as zero.
  always_ff @(posedge i_clk25m) begin
    if (i_rst_clk25m) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= {w_push_addr, i_cam_data};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk25m) begin
    if (i_rst_clk25m) begin
      r_rd_pend  <= 1'b0;
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      r_rd_pend  <= i_rd_en;
      o_rd_valid <= r_rd_pend;
      if (r_rd_pend) begin
        o_rd_data <= i_bram_rdata;
      end
    end
  end

endmodule
